// File: rtl/fft2ram.sv
// Captures one FFT frame, writes re^2+im^2 for the lower half of the bins into a ping-pong RAM bank and hands the bank to the Nios.
// Beat to RAM write takes 2 cycles. source_ready is held high, so the FFT is never stalled; frames are dropped when no bank is free.
module fft2ram #(
  parameter int FFT_POINTS = 1024,
  parameter int FFT_BUS    = 9,
  parameter int DATA_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  source_valid,
  input  logic                  source_sop,
  input  logic                  source_eop,
  input  logic [1:0]            source_error,
  input  logic [DATA_W-1:0]     source_real,
  input  logic [DATA_W-1:0]     source_imag,
  input  logic [5:0]            source_exp,
  output logic                  source_ready,
  output logic                  ram_wren,
  output logic [FFT_BUS:0]      ram_waddr,
  output logic [2*DATA_W-1:0]   ram_wdata,
  output logic                  frame_ready,
  output logic                  frame_bank,
  output logic [5:0]            frame_exp,
  input  logic                  frame_ack,
  output logic [7:0]            drop_count,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

  // FFT_POINTS is a power of two, so the last bin index is all ones.
  localparam logic [FFT_BUS:0] LAST_BIN = '1;

  state_t              state_q;
  logic [FFT_BUS:0]    cnt_q;
  logic                flush_q;
  logic                bad_q;
  logic [5:0]          pexp_q;
  logic                wr_bank_q;
  logic                src_rdy_q;
  logic                frame_ready_q;
  logic                frame_bank_q;
  logic [5:0]          frame_exp_q;
  logic [7:0]          drop_q;
  logic [7:0]          err_q;

  logic                s1_vld_q;
  logic [FFT_BUS:0]    s1_addr_q;
  logic [2*DATA_W-1:0] s1_re2_q;
  logic [2*DATA_W-1:0] s1_im2_q;
  logic                wren_q;
  logic [FFT_BUS:0]    waddr_q;
  logic [2*DATA_W-1:0] wdata_q;

  logic                issue;
  logic [FFT_BUS:0]    bin;
  logic                last_bin;
  logic                ready_after_ack;

  always_comb begin
    issue = 1'b0;
    bin   = cnt_q;
    case (state_q)
      IDLE: begin
        issue = source_valid & source_sop;
        bin   = '0;
      end
      CAPTURE: issue = source_valid;
      default: issue = 1'b0;
    endcase
    last_bin        = (cnt_q == LAST_BIN);
    ready_after_ack = frame_ready_q & ~frame_ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      bad_q         <= 1'b0;
      pexp_q        <= '0;
      wr_bank_q     <= 1'b0;
      src_rdy_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_bank_q  <= 1'b0;
      frame_exp_q   <= '0;
      drop_q        <= '0;
      err_q         <= '0;
    end else begin
      src_rdy_q <= 1'b1;
      if (frame_ack) frame_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (source_valid && source_sop) begin
            cnt_q   <= {{FFT_BUS{1'b0}}, 1'b1};
            pexp_q  <= source_exp;
            bad_q   <= |source_error;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (source_valid) begin
            cnt_q <= cnt_q + 1'b1;
            // eop must coincide exactly with the last bin; anything else is malformed
            if (|source_error || source_sop || (source_eop != last_bin)) bad_q <= 1'b1;
            if (source_eop || last_bin) begin
              state_q <= FLUSH;
              flush_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (!flush_q) begin
            flush_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            if (bad_q) begin
              if (err_q != 8'hFF) err_q <= err_q + 1'b1;
            end else if (!ready_after_ack) begin
              frame_ready_q <= 1'b1;
              frame_bank_q  <= wr_bank_q;
              frame_exp_q   <= pexp_q;
              wr_bank_q     <= ~wr_bank_q;
            end else begin
              if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_re2_q  <= '0;
      s1_im2_q  <= '0;
      wren_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      // upper-half bins still flow through the multipliers but never reach the RAM
      s1_vld_q <= issue & ~bin[FFT_BUS];
      if (issue) begin
        s1_addr_q <= {wr_bank_q, bin[FFT_BUS-1:0]};
        s1_re2_q  <= $signed(source_real) * $signed(source_real);
        s1_im2_q  <= $signed(source_imag) * $signed(source_imag);
      end
      wren_q <= s1_vld_q;
      if (s1_vld_q) begin
        waddr_q <= s1_addr_q;
        wdata_q <= s1_re2_q + s1_im2_q;
      end
    end
  end

  assign source_ready = src_rdy_q;
  assign ram_wren     = wren_q;
  assign ram_waddr    = waddr_q;
  assign ram_wdata    = wdata_q;
  assign frame_ready  = frame_ready_q;
  assign frame_bank   = frame_bank_q;
  assign frame_exp    = frame_exp_q;
  assign drop_count   = drop_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_fft2ram.sv
// Scoreboarded bench for fft2ram with a 16-point frame; RAM writes are checked by a monitor, handshake state directly.
module tb_fft2ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        source_valid, source_sop, source_eop;
  logic [1:0]  source_error;
  logic [15:0] source_real, source_imag;
  logic [5:0]  source_exp;
  logic        source_ready;
  logic        ram_wren;
  logic [3:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic        frame_ready, frame_bank;
  logic [5:0]  frame_exp;
  logic        frame_ack;
  logic [7:0]  drop_count, err_count;

  fft2ram #(.FFT_POINTS(16), .FFT_BUS(3), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_error(source_error), .source_real(source_real), .source_imag(source_imag),
    .source_exp(source_exp), .source_ready(source_ready),
    .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .frame_ready(frame_ready), .frame_bank(frame_bank), .frame_exp(frame_exp),
    .frame_ack(frame_ack), .drop_count(drop_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ram_wren) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", ram_waddr, -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", ram_waddr, e.addr);
        chk("wr_data", ram_wdata, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic beat(input logic v, input logic sop, input logic eop, input logic [1:0] err,
                      input int re, input int im, input logic [5:0] ex);
    source_valid = v;
    source_sop   = sop;
    source_eop   = eop;
    source_error = err;
    source_real  = re[15:0];
    source_imag  = im[15:0];
    source_exp   = ex;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 6'd0);
  endtask

  // Returns two cycles after the eop beat was presented.
  task automatic send_frame(input int re, input int im, input logic [5:0] ex, input int eop_at,
                            input int err_at, input logic [1:0] err_val, input logic gap,
                            input logic bank);
    for (int i = 0; i <= eop_at; i++) begin
      if (i < 8) begin
        wr_t w;
        logic [2:0] b3;
        b3 = i[2:0];
        w.cyc = cyc + 2;
        w.addr = {bank, b3};
        w.data = re * re + im * im;
        exp_q.push_back(w);
      end
      beat(1'b1, i == 0, i == eop_at, (i == err_at) ? err_val : 2'd0, re, im, ex);
      if (gap && i != eop_at) beat(1'b0, i == 2, 1'b0, 2'd0, 0, 0, 6'd0);
    end
    beat(1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 6'd0);
  endtask

  task automatic check_state(input string tag, input logic rdy, input logic bank,
                             input int ex, input int drop, input int err);
    chk({tag, "_frame_ready"}, frame_ready, rdy);
    chk({tag, "_frame_bank"}, frame_bank, bank);
    chk({tag, "_frame_exp"}, frame_exp, ex);
    chk({tag, "_drop_count"}, drop_count, drop);
    chk({tag, "_err_count"}, err_count, err);
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    frame_ack = 1'b0;
    source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    source_error = 2'd0; source_real = '0; source_imag = '0; source_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_source_ready", source_ready, 0);
    chk("rst_ram_wren", ram_wren, 0);
    check_state("rst", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("source_ready_after_reset", source_ready, 1);
    idle(2);

    // A: 3,-4 -> 25 into bank 0, frame_ready exactly three cycles after eop
    send_frame(3, -4, 6'd5, 15, -1, 2'd0, 1'b0, 1'b0);
    chk("A_ready_eop_plus2", frame_ready, 0);
    @(posedge clk); #1;
    check_state("A", 1, 0, 5, 0, 0);
    idle(3);
    ack_pulse();
    idle(1);
    check_state("ack1", 0, 0, 5, 0, 0);

    // B: 1,2 -> 5 into bank 1
    send_frame(1, 2, 6'd7, 15, -1, 2'd0, 1'b0, 1'b1);
    idle(2);
    check_state("B", 1, 1, 7, 0, 0);

    // C: no ack, so the frame is written to bank 0 and dropped
    send_frame(-5, 12, 6'd9, 15, -1, 2'd0, 1'b0, 1'b0);
    idle(2);
    check_state("C_drop", 1, 1, 7, 1, 0);

    // D: early eop at beat 10; E: error code on beat 5
    send_frame(2, 0, 6'd3, 10, -1, 2'd0, 1'b0, 1'b0);
    idle(2);
    check_state("D_early_eop", 1, 1, 7, 1, 1);
    send_frame(6, 6, 6'd4, 15, 5, 2'd2, 1'b0, 1'b0);
    idle(2);
    check_state("E_error", 1, 1, 7, 1, 2);

    ack_pulse();
    idle(1);
    check_state("ack2", 0, 1, 7, 1, 2);

    // F: gapped stream with a valid=0 sop in the gaps
    send_frame(3, -4, 6'd11, 15, -1, 2'd0, 1'b1, 1'b0);
    idle(2);
    check_state("F_gapped", 1, 0, 11, 1, 2);

    // G: ack lands on the publish cycle
    send_frame(7, -1, 6'd13, 15, -1, 2'd0, 1'b0, 1'b1);
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    check_state("G_ack_publish", 1, 1, 13, 1, 2);
    idle(3);

    // H: reset mid-frame at beat 6; beats 0..3 reach the RAM before reset
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        wr_t w;
        logic [2:0] b3;
        b3 = i[2:0];
        w.cyc = cyc + 2;
        w.addr = {1'b0, b3};
        w.data = 32'd25;
        exp_q.push_back(w);
      end
      beat(1'b1, i == 0, 1'b0, 2'd0, 3, -4, 6'd17);
    end
    reset_n = 1'b0;
    source_valid = 1'b0;
    #1;
    chk("H_rst_ram_wren", ram_wren, 0);
    chk("H_rst_source_ready", source_ready, 0);
    check_state("H_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);

    // I: after reset the writer is back on bank 0
    send_frame(-3, 4, 6'd21, 15, -1, 2'd0, 1'b0, 1'b0);
    chk("I_ready_eop_plus2", frame_ready, 0);
    @(posedge clk); #1;
    check_state("I", 1, 0, 21, 0, 0);
    idle(5);

    chk("writes_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
